// File: rtl/sprite_line_fetch_if.sv
// Sprite ROM read port: the fetcher drives the address, the ROM returns data one Clk later.
interface sprite_line_fetch_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/sprite_line_fetch.sv
// Per-scanline sprite source: fetches one sprite row into a line buffer during hblank,
// then serves is_sprite/sprite_data during active video. Define SPRITE_MIRROR_EN for facing-based flip.
module sprite_line_fetch #(
    parameter int SPR_W  = 32,
    parameter int SPR_H  = 32,
    parameter int ADDR_W = 10
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [9:0]          DrawX,
    input  logic [9:0]          DrawY,
    input  logic [9:0]          sprite_x,
    input  logic [9:0]          sprite_y,
    input  logic                facing,
    sprite_line_fetch_if.master rom,
    output logic                is_sprite,
    output logic [3:0]          sprite_data
);
    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam logic [10:0]       W_L    = 11'(SPR_W);
    localparam logic [10:0]       H_L    = 11'(SPR_H);
    localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(SPR_W);
    localparam logic [CW-1:0]     C_LAST = CW'(SPR_W - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     c_q, c_d, c_prev_q, c_nx;
    logic              rd_vld_q;
    logic [ADDR_W-1:0] base_q, base_d, rom_addr_q, rom_addr_d, col0, coln;
    logic [9:0]        px_q, px_d, py_q, py_d;
    logic              lv_q, lv_d, lvn_q, lvn_d;
    logic              is_sprite_q, is_sprite_d;
    logic [3:0]        sprite_data_q, sprite_data_d;
    logic [9:0]        tl, r, off;
    logic              row_ok, hit;
    logic [3:0]        linebuf_q [SPR_W];
`ifdef SPRITE_MIRROR_EN
    logic              pf_q, pf_d;
`else
    logic              unused_facing;
    assign unused_facing = facing;
`endif

    always_comb begin
        state_d    = state_q;
        c_d        = c_q;
        c_nx       = c_q + 1'b1;
        base_d     = base_q;
        rom_addr_d = rom_addr_q;
        px_d       = px_q;
        py_d       = py_q;
        lv_d       = lv_q;
        lvn_d      = lvn_q;
`ifdef SPRITE_MIRROR_EN
        pf_d       = pf_q;
        col0       = pf_q ? ADDR_W'(C_LAST) : '0;
        coln       = ADDR_W'(pf_q ? (C_LAST - c_nx) : c_nx);
`else
        col0       = '0;
        coln       = ADDR_W'(c_nx);
`endif
        // No wrap: the next line after 524 is 0, and rows above py never match.
        tl     = (DrawY == 10'd524) ? 10'd0 : DrawY + 10'd1;
        r      = tl - py_q;
        row_ok = (tl >= py_q) && ({1'b0, r} < H_L);

        if (DrawY == 10'd480 && DrawX == 10'd0) begin
            px_d = sprite_x;
            py_d = sprite_y;
`ifdef SPRITE_MIRROR_EN
            pf_d = facing;
`endif
        end
        if (DrawX == 10'd0) lv_d = lvn_q;

        // rom_addr_q always carries the address for the current c_q while in FETCH.
        case (state_q)
            IDLE: if (DrawX == 10'd640) begin
                lvn_d = 1'b0;
                if (row_ok) begin
                    state_d    = FETCH;
                    c_d        = '0;
                    base_d     = ADDR_W'(r) * W_A;
                    rom_addr_d = ADDR_W'(r) * W_A + col0;
                end
            end
            FETCH: begin
                c_d = c_nx;
                if (c_q == C_LAST) state_d = DRAIN;
                else rom_addr_d = base_q + coln;
            end
            DRAIN: begin
                lvn_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        off           = DrawX - px_q;
        hit           = lv_q && (DrawX < 10'd640) && (DrawX >= px_q) && ({1'b0, off} < W_L);
        is_sprite_d   = hit;
        sprite_data_d = hit ? linebuf_q[off[CW-1:0]] : 4'd0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= IDLE;
            c_q           <= '0;
            c_prev_q      <= '0;
            rd_vld_q      <= 1'b0;
            base_q        <= '0;
            rom_addr_q    <= '0;
            px_q          <= '0;
            py_q          <= '0;
            lv_q          <= 1'b0;
            lvn_q         <= 1'b0;
            is_sprite_q   <= 1'b0;
            sprite_data_q <= 4'd0;
`ifdef SPRITE_MIRROR_EN
            pf_q          <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            c_q           <= c_d;
            c_prev_q      <= c_q;
            rd_vld_q      <= (state_q == FETCH);
            base_q        <= base_d;
            rom_addr_q    <= rom_addr_d;
            px_q          <= px_d;
            py_q          <= py_d;
            lv_q          <= lv_d;
            lvn_q         <= lvn_d;
            is_sprite_q   <= is_sprite_d;
            sprite_data_q <= sprite_data_d;
`ifdef SPRITE_MIRROR_EN
            pf_q          <= pf_d;
`endif
        end
    end

    always_ff @(posedge Clk) begin
        if (rd_vld_q) linebuf_q[c_prev_q] <= rom.rom_data;
    end

    assign rom.rom_addr = rom_addr_q;
    assign is_sprite    = is_sprite_q;
    assign sprite_data  = sprite_data_q;
endmodule

// File: tb/tb_sprite_line_fetch.sv
// Randomized bench for sprite_line_fetch against a line-level reference model of the scan rules.
module tb_sprite_line_fetch;
    localparam int W = 32, H = 32, AW = 10;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [9:0] DrawX, DrawY, sprite_x, sprite_y;
    logic       facing;
    logic       is_sprite;
    logic [3:0] sprite_data;
    logic [3:0] rom_mem [1024];

    sprite_line_fetch_if #(.ADDR_W(AW)) rom_if ();

    sprite_line_fetch #(.SPR_W(W), .SPR_H(H), .ADDR_W(AW)) dut (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .facing(facing),
        .rom(rom_if), .is_sprite(is_sprite), .sprite_data(sprite_data)
    );

    always #5 Clk = ~Clk;
    always_ff @(posedge Clk) rom_if.rom_data <= rom_mem[rom_if.rom_addr];

    int total = 0, bad = 0;
    int m_px, m_py, m_addr, m_row, m_rown;
    bit m_pf, m_pfr, m_pfn, m_lv, m_lvn;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s Y=%0d X=%0d got=%0d exp=%0d", tag, DrawY, DrawX, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_px = 0; m_py = 0; m_pf = 0; m_lv = 0; m_lvn = 0; m_addr = 0;
    endfunction

    task automatic pix(input int x);
        int off, exp_d;
        bit exp_h;
        DrawX = 10'(x);
        if (x == 0) begin
            if (DrawY == 10'd480) begin
                m_px = int'(sprite_x);
                m_py = int'(sprite_y);
`ifdef SPRITE_MIRROR_EN
                m_pf = facing;
`endif
            end
            m_lv = m_lvn; m_row = m_rown; m_pfr = m_pfn;
        end
        repeat (2) @(posedge Clk);
        #1;
        off   = x - m_px;
        exp_h = m_lv && (x < 640) && (off >= 0) && (off < W);
        exp_d = exp_h ? int'(rom_mem[m_row * W + (m_pfr ? W - 1 - off : off)]) : 0;
        chk("is_sprite", 32'(is_sprite), 32'(exp_h));
        chk("sprite_data", 32'(sprite_data), 32'(exp_d));
    endtask

    // rst_k >= 0 pulses Reset for one edge after hblank clock rst_k.
    task automatic hblank(input int rst_k);
        int tl, row;
        bit fetch, pfn;
        tl    = (DrawY == 10'd524) ? 0 : int'(DrawY) + 1;
        fetch = (tl >= m_py) && (tl - m_py < H);
        row   = tl - m_py;
        pfn   = m_pf;
        m_lvn = 0;
        DrawX = 10'd640;
        for (int k = 0; k < 40; k++) begin
            @(posedge Clk);
            #1;
            if (rst_k >= 0 && k == rst_k + 1) begin
                Reset = 1'b0;
                model_reset();
                fetch = 0;
            end else if (fetch && k < W) begin
                m_addr = row * W + (pfn ? W - 1 - k : k);
            end
            chk("rom_addr", 32'(rom_if.rom_addr), 32'(m_addr));
            if (rst_k >= 0 && k == rst_k) Reset = 1'b1;
            if (k % 2 == 1) DrawX = DrawX + 10'd1;
        end
        if (fetch) begin
            m_lvn = 1; m_rown = row; m_pfn = pfn;
        end
    endtask

    task automatic line(input int y, input int rst_k);
        int lo, hi;
        DrawY = 10'(((y % 525) + 525) % 525);
        pix(0);
        lo = (m_px - 2 < 0) ? 0 : m_px - 2;
        hi = (m_px + W + 1 > 639) ? 639 : m_px + W + 1;
        for (int x = lo; x <= hi; x++) pix(x);
        repeat (3) pix($urandom_range(1, 639));
        pix(639);
        hblank(rst_k);
    endtask

    task automatic set_sprite(input int sx, input int sy, input bit f);
        sprite_x = 10'(sx); sprite_y = 10'(sy); facing = f;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom_mem[i] = 4'($urandom_range(0, 15));
        Reset = 1'b1; DrawX = 10'd700; DrawY = 10'd10;
        sprite_x = 10'd0; sprite_y = 10'd0; facing = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        model_reset();
        chk("rst_is_sprite", 32'(is_sprite), 32'd0);
        chk("rst_sprite_data", 32'(sprite_data), 32'd0);
        chk("rst_rom_addr", 32'(rom_if.rom_addr), 32'd0);
        Reset = 1'b0;

        // Nominal placement, including line-0 fetch during line 524.
        set_sprite(100, 50, 1'($urandom_range(0, 1)));
        line(480, -1); line(524, -1); line(0, -1);
        for (int y = 48; y <= 83; y++) line(y, -1);
        line(200, -1);

        // Right-edge clip.
        set_sprite(620, 120, 1'($urandom_range(0, 1)));
        line(480, -1);
        for (int y = 119; y <= 123; y++) line(y, -1);
        for (int y = 150; y <= 152; y++) line(y, -1);

        // Top row via the 524 -> 0 wrap, then a sprite that never appears.
        set_sprite(int'($urandom_range(0, 639)), 0, 1'($urandom_range(0, 1)));
        line(480, -1); line(523, -1); line(524, -1); line(0, -1); line(1, -1);
        line(30, -1); line(31, -1); line(32, -1);
        set_sprite(int'($urandom_range(0, 639)), 1020, 1'b0);
        line(480, -1); line(523, -1); line(524, -1); line(0, -1); line(1, -1); line(100, -1);

        // Mid-frame move only takes effect after the next frame latch.
        set_sprite(100, 190, 1'b0);
        line(480, -1); line(189, -1); line(190, -1); line(199, -1);
        sprite_x = 10'd300;
        line(200, -1); line(201, -1); line(210, -1);
        line(480, -1); line(189, -1); line(190, -1); line(200, -1);

        // Reset in the middle of a fetch.
        set_sprite(int'($urandom_range(0, 600)), 50, 1'b0);
        line(480, -1); line(57, -1); line(58, -1); line(59, 10);
        line(60, -1); line(61, -1); line(62, -1);
        line(480, -1); line(49, -1); line(50, -1); line(51, -1);

        repeat (3) begin
            int sy;
            sy = int'($urandom_range(0, 500));
            set_sprite(int'($urandom_range(0, 639)), sy, 1'($urandom_range(0, 1)));
            line(480, -1);
            repeat (4) line(int'($urandom_range(0, 524)), -1);
            line(sy - 1, -1); line(sy, -1); line(sy + H - 1, -1); line(sy + H, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
